// File: rtl/coord_pair_scheduler_pkg.sv
// Shared accelerator definitions for the coordinate pair scheduler: FSM states,
// default sizes and the count-width helper.
`ifndef num_of_Conv_Layer
`define num_of_Conv_Layer 4
`endif

package coord_pair_scheduler_pkg;

    localparam int LAYER_W       = `num_of_Conv_Layer + 1;
    localparam int DEF_MAX_IVECS = 64;
    localparam int DEF_MAX_FVECS = 16;
    localparam int DEF_ADDR_W    = 10;
    localparam int STALL_W       = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Bits needed to hold a count from 0 up to and including max_cnt.
    function automatic int cnt_width(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/coord_pair_scheduler_vec_pair_counter.sv
// Nested activation/weight vector counters (weight outer, activation inner) that
// report the last-vector flags of the pair that follows the current one.
module coord_pair_scheduler_vec_pair_counter
    import coord_pair_scheduler_pkg::*;
#(
    parameter int IW = 7,
    parameter int FW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_advance,
    input  logic [IW-1:0] i_num_i,
    input  logic [FW-1:0] i_num_f,
    output logic          o_nxt_last_i,
    output logic          o_nxt_last_pair
);

    logic [IW-1:0] r_i_cnt;
    logic [FW-1:0] r_f_cnt;
    logic [IW-1:0] w_i_nxt;
    logic [FW-1:0] w_f_nxt;
    logic          w_last_i;

    assign w_last_i = (r_i_cnt == (i_num_i - IW'(1)));

    // Next-count selection: clear, inner wrap with outer step, inner step, or hold.
    always_comb begin
        w_i_nxt = r_i_cnt;
        w_f_nxt = r_f_cnt;
        if (i_clear) begin
            w_i_nxt = '0;
            w_f_nxt = '0;
        end else if (i_advance) begin
            if (w_last_i) begin
                w_i_nxt = '0;
                w_f_nxt = r_f_cnt + FW'(1);
            end else begin
                w_i_nxt = r_i_cnt + IW'(1);
                w_f_nxt = r_f_cnt;
            end
        end else begin
            w_i_nxt = r_i_cnt;
            w_f_nxt = r_f_cnt;
        end
    end

    // Flags describing the pair that will be presented after this cycle.
    always_comb begin
        o_nxt_last_i    = (w_i_nxt == (i_num_i - IW'(1)));
        o_nxt_last_pair = o_nxt_last_i && (w_f_nxt == (i_num_f - FW'(1)));
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_cnt <= '0;
            r_f_cnt <= '0;
        end else begin
            r_i_cnt <= w_i_nxt;
            r_f_cnt <= w_f_nxt;
        end
    end

endmodule

// File: rtl/coord_pair_scheduler.sv
// Tile job scheduler: sweeps every activation vector against each weight vector
// of a filter group and issues (activation, weight) address pairs downstream.
module coord_pair_scheduler
    import coord_pair_scheduler_pkg::*;
#(
    parameter int MAX_IVECS = DEF_MAX_IVECS,
    parameter int MAX_FVECS = DEF_MAX_FVECS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              flush,
    input  logic [LAYER_W-1:0]                layer_id,
    input  logic [cnt_width(MAX_IVECS)-1:0]   num_ivecs,
    input  logic [cnt_width(MAX_FVECS)-1:0]   num_fvecs,
    input  logic [ADDR_W-1:0]                 i_base,
    input  logic [ADDR_W-1:0]                 w_base,
    input  logic                              issue_ready,
    output logic                              issue_valid,
    output logic [ADDR_W-1:0]                 i_addr,
    output logic [ADDR_W-1:0]                 w_addr,
    output logic                              last_decode_input,
    output logic                              last_pair,
    output logic                              layer_change,
    output logic                              busy,
    output logic                              done,
    output logic [STALL_W-1:0]                stall_cnt
);

    localparam int IW = cnt_width(MAX_IVECS);
    localparam int FW = cnt_width(MAX_FVECS);

    sched_state_t        r_state;
    logic [IW-1:0]       r_num_i;
    logic [FW-1:0]       r_num_f;
    logic [ADDR_W-1:0]   r_i_base;
    logic [ADDR_W-1:0]   r_w_base;
    logic [LAYER_W-1:0]  r_layer;
    logic [LAYER_W-1:0]  r_prev_layer;
    logic                r_issue_valid;
    logic [ADDR_W-1:0]   r_i_addr;
    logic [ADDR_W-1:0]   r_w_addr;
    logic                r_last_dec;
    logic                r_last_pair;
    logic                r_layer_change;
    logic                r_busy;
    logic                r_done;
    logic [STALL_W-1:0]  r_stall_cnt;

    logic                w_clear;
    logic                w_advance;
    logic                w_nxt_last_i;
    logic                w_nxt_last_pair;

    assign w_clear   = (r_state == ST_LOAD);
    assign w_advance = (r_state == ST_ISSUE) && issue_ready && !flush;

    coord_pair_scheduler_vec_pair_counter #(
        .IW (IW),
        .FW (FW)
    ) u_vec_pair_counter (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (w_clear),
        .i_advance       (w_advance),
        .i_num_i         (r_num_i),
        .i_num_f         (r_num_f),
        .o_nxt_last_i    (w_nxt_last_i),
        .o_nxt_last_pair (w_nxt_last_pair)
    );

    // Job FSM with all downstream-visible outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_num_i        <= '0;
            r_num_f        <= '0;
            r_i_base       <= '0;
            r_w_base       <= '0;
            r_layer        <= '0;
            r_prev_layer   <= '0;
            r_issue_valid  <= 1'b0;
            r_i_addr       <= '0;
            r_w_addr       <= '0;
            r_last_dec     <= 1'b0;
            r_last_pair    <= 1'b0;
            r_layer_change <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_stall_cnt    <= '0;
        end else if (flush) begin
            // Abort discards the job silently; stall_cnt keeps its last value.
            r_state        <= ST_IDLE;
            r_issue_valid  <= 1'b0;
            r_last_dec     <= 1'b0;
            r_last_pair    <= 1'b0;
            r_layer_change <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_num_i        <= num_ivecs;
                        r_num_f        <= num_fvecs;
                        r_i_base       <= i_base;
                        r_w_base       <= w_base;
                        r_layer        <= layer_id;
                        r_layer_change <= (layer_id != r_prev_layer);
                        r_busy         <= 1'b1;
                        r_state        <= ST_LOAD;
                    end else begin
                        r_layer_change <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_layer_change <= 1'b0;
                    r_prev_layer   <= r_layer;
                    r_stall_cnt    <= '0;
                    r_i_addr       <= r_i_base;
                    r_w_addr       <= r_w_base;
                    if ((r_num_i == IW'(0)) || (r_num_f == FW'(0))) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_issue_valid <= 1'b1;
                        r_last_dec    <= w_nxt_last_i;
                        r_last_pair   <= w_nxt_last_pair;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!issue_ready) begin
                        if (r_stall_cnt != STALL_MAX) begin
                            r_stall_cnt <= r_stall_cnt + 16'd1;
                        end else begin
                            r_stall_cnt <= r_stall_cnt;
                        end
                    end else if (r_last_pair) begin
                        r_issue_valid <= 1'b0;
                        r_last_dec    <= 1'b0;
                        r_last_pair   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        // Address registers track the counters so outputs stay registered.
                        if (r_last_dec) begin
                            r_i_addr <= r_i_base;
                            r_w_addr <= r_w_addr + ADDR_W'(1);
                        end else begin
                            r_i_addr <= r_i_addr + ADDR_W'(1);
                            r_w_addr <= r_w_addr;
                        end
                        r_last_dec  <= w_nxt_last_i;
                        r_last_pair <= w_nxt_last_pair;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_issue_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign issue_valid       = r_issue_valid;
    assign i_addr            = r_i_addr;
    assign w_addr            = r_w_addr;
    assign last_decode_input = r_last_dec;
    assign last_pair         = r_last_pair;
    assign layer_change      = r_layer_change;
    assign busy              = r_busy;
    assign done              = r_done;
    assign stall_cnt         = r_stall_cnt;

endmodule

// File: tb/tb_coord_pair_scheduler.sv
// Scoreboard bench for coord_pair_scheduler: expected pairs are queued at job
// start and popped as the scheduler hands pairs downstream.
module tb_coord_pair_scheduler;
    import coord_pair_scheduler_pkg::*;

    localparam int AW = 10;
    localparam int IW = 7;
    localparam int FW = 5;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               flush;
    logic [LAYER_W-1:0] layer_id;
    logic [IW-1:0]      num_ivecs;
    logic [FW-1:0]      num_fvecs;
    logic [AW-1:0]      i_base;
    logic [AW-1:0]      w_base;
    logic               issue_ready;
    logic               issue_valid;
    logic [AW-1:0]      i_addr;
    logic [AW-1:0]      w_addr;
    logic               last_decode_input;
    logic               last_pair;
    logic               layer_change;
    logic               busy;
    logic               done;
    logic [15:0]        stall_cnt;

    typedef struct packed {
        logic [AW-1:0] ia;
        logic [AW-1:0] wa;
        logic          ld;
        logic          lp;
    } pair_t;

    pair_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_acc    = 0;
    int    n_valid  = 0;
    int    n_done   = 0;
    logic  exp_done_next = 1'b0;

    coord_pair_scheduler #(
        .MAX_IVECS (64),
        .MAX_FVECS (16),
        .ADDR_W    (AW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .flush             (flush),
        .layer_id          (layer_id),
        .num_ivecs         (num_ivecs),
        .num_fvecs         (num_fvecs),
        .i_base            (i_base),
        .w_base            (w_base),
        .issue_ready       (issue_ready),
        .issue_valid       (issue_valid),
        .i_addr            (i_addr),
        .w_addr            (w_addr),
        .last_decode_input (last_decode_input),
        .last_pair         (last_pair),
        .layer_change      (layer_change),
        .busy              (busy),
        .done              (done),
        .stall_cnt         (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {22'd0, issue_valid, i_addr, w_addr, last_decode_input, last_pair,
                layer_change, busy, done, stall_cnt};
    endfunction

    task automatic push_job(input int ni, input int nf, input logic [AW-1:0] ib,
                            input logic [AW-1:0] wb);
        pair_t p;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < ni; i++) begin
                p.ia = AW'(int'(ib) + i);
                p.wa = AW'(int'(wb) + f);
                p.ld = (i == ni - 1);
                p.lp = (i == ni - 1) && (f == nf - 1);
                sb.push_back(p);
            end
        end
    endtask

    task automatic start_job(input int ni, input int nf, input logic [AW-1:0] ib,
                             input logic [AW-1:0] wb, input int lay);
        push_job(ni, nf, ib, wb);
        @(posedge clk); #1;
        num_ivecs = IW'(ni);
        num_fvecs = FW'(nf);
        i_base    = ib;
        w_base    = wb;
        layer_id  = LAYER_W'(lay);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Cycles counted from the LOAD cycle; layer_change and busy sampled in LOAD.
    task automatic wait_done(input int max_cyc, output int cyc, output logic lc);
        cyc = 0;
        lc  = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                lc = layer_change;
                check("busy_in_load", busy, 1);
            end
        end while (!done && cyc < max_cyc);
        check("done_seen", done, 1);
    endtask

    task automatic wait_acc(input int target);
        int guard = 0;
        while (n_acc < target && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        check("reach_acc", n_acc >= target, 1);
    endtask

    // Scoreboard monitor sampling on the falling edge.
    initial begin
        pair_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done_next = 1'b0;
            end else begin
                if (exp_done_next) check("done_after_last", done, 1);
                exp_done_next = 1'b0;
                if (done) begin
                    n_done++;
                    check("sb_empty_at_done", sb.size(), 0);
                end
                if (issue_valid) n_valid++;
                if (issue_valid && !flush) begin
                    if (issue_ready) begin
                        check("pair_avail", sb.size() > 0, 1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check("pair", {42'd0, i_addr, w_addr, last_decode_input, last_pair}, {42'd0, e});
                            n_acc++;
                            if (e.lp) exp_done_next = 1'b1;
                        end
                    end else if (sb.size() > 0) begin
                        check("hold_addr", {i_addr, w_addr}, {sb[0].ia, sb[0].wa});
                    end
                end
            end
        end
    end

    initial begin
        int   cyc;
        logic lc;
        int   acc0;
        int   d0;
        int   v0;
        int   prev_model;
        int   lays[3];

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; layer_id = '0;
        num_ivecs = '0; num_fvecs = '0; i_base = '0; w_base = '0; issue_ready = 1'b1;
        #2;
        check("reset_outputs", all_outs(), 64'd0);
        #10 rst_n = 1'b1;
        prev_model = 0;

        // Basic 3x2 job at full throughput.
        acc0 = n_acc;
        start_job(3, 2, 10'h010, 10'h040, 0);
        wait_done(40, cyc, lc);
        check("a_cycles", cyc, 8);
        check("a_layer_change", lc, 0);
        check("a_pairs", n_acc - acc0, 6);
        check("a_stall", stall_cnt, 0);

        // Same job with a 4-cycle backpressure window on pair 2.
        acc0 = n_acc;
        start_job(3, 2, 10'h010, 10'h040, 0);
        wait_acc(acc0 + 1);
        @(posedge clk); #1;
        issue_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 issue_ready = 1'b1;
        wait_done(40, cyc, lc);
        check("b_stall", stall_cnt, 4);
        check("b_pairs", n_acc - acc0, 6);

        // Zero-length job.
        v0 = n_valid;
        start_job(0, 5, 10'h010, 10'h040, 0);
        wait_done(10, cyc, lc);
        check("zero_cycles", cyc, 2);
        check("zero_no_valid", n_valid - v0, 0);

        // Address wrap at the top of the buffer.
        acc0 = n_acc;
        start_job(4, 2, 10'h3FE, 10'h3FF, 0);
        wait_done(40, cyc, lc);
        check("wrap_cycles", cyc, 10);
        check("wrap_pairs", n_acc - acc0, 8);

        // Layer change tracking.
        lays = '{1, 1, 2};
        for (int j = 0; j < 3; j++) begin
            start_job(1, 1, 10'h000, 10'h000, lays[j]);
            wait_done(10, cyc, lc);
            check("layer_change", lc, (lays[j] != prev_model));
            prev_model = lays[j];
        end

        // Flush during pair 4, with a simultaneous handshake.
        acc0 = n_acc;
        d0   = n_done;
        start_job(3, 2, 10'h020, 10'h050, 2);
        wait_acc(acc0 + 3);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_valid", issue_valid, 0);
        check("flush_busy", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        check("flush_no_done", n_done - d0, 0);
        check("flush_pairs", n_acc - acc0, 3);

        acc0 = n_acc;
        start_job(3, 2, 10'h010, 10'h040, 2);
        wait_done(40, cyc, lc);
        check("post_flush_cycles", cyc, 8);
        check("post_flush_pairs", n_acc - acc0, 6);

        // Asynchronous reset in the middle of issuing.
        acc0 = n_acc;
        d0   = n_done;
        start_job(2, 3, 10'h100, 10'h200, 3);
        wait_acc(acc0 + 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_async", all_outs(), 64'd0);
        sb.delete();
        #12 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_no_done", n_done - d0, 0);

        // Previous layer register must have been cleared by reset.
        acc0 = n_acc;
        start_job(2, 2, 10'h000, 10'h000, 0);
        wait_done(40, cyc, lc);
        check("post_reset_layer_change", lc, 0);
        check("post_reset_pairs", n_acc - acc0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
